alu_div_seq: RTL and testbench

Iterative 32-bit integer divider for the ALU datapath. It accepts a dividend/divisor pair with a start pulse and computes one quotient bit per cycle using restoring division. It then presents the registered quotient and remainder with a one-cycle done pulse. The quotient output feeds the ALU's 32-to-1 zero-flag detector directly, so it stays stable between operations.

---
 rtl/alu_div_seq.sv | 138 +++++++++++++
 tb/tb_alu_div_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - iterative 32-bit restoring divider, signed/unsigned, one quotient bit per cycle
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // The 33-bit partial remainder only exists transiently as 'shifted'; after
  // a successful trial subtract the result is below the divisor, so W bits suffice.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted[WIDTH-1:0] - dvs_q;

    state_d   = state_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    dz_d      = dz_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_dvd_d = signed_op & dividend[WIDTH-1];
          neg_dvs_d = signed_op & divisor[WIDTH-1];
          dvs_d     = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
          rem_d     = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            // Keep the raw dividend: it is returned unmodified as the remainder.
            dz_d    = 1'b1;
            dvd_d   = dividend;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = ge ? diff : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quo_d = '1;
          rmd_d = dvd_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = (neg_dvd_q ^ neg_dvs_q) ? -dvd_q : dvd_q;
          rmd_d = neg_dvd_q ? -rem_q : rem_q;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      dz_q      <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      dz_q      <= dz_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - self-checking bench for alu_div_seq: vector table, random ops, handshake and reset sequences
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with 64-bit signed arithmetic.
  function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sop) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q = tq[31:0]; r = tr[31:0]; dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic [31:0] pq, pr;
    logic        pdz;
    int          hold_err;
    pq = quotient; pr = remainder; pdz = div_by_zero;
    hold_err = 0;
    @(negedge clk);
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; signed_op = $urandom; dividend = $urandom; divisor = $urandom;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (quotient !== pq || remainder !== pr || div_by_zero !== pdz) hold_err = 1;
    end
    q = quotient; r = remainder; dz = div_by_zero;
    chk("hold_during_run", 32'(hold_err), 32'd0);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic check_op(input string tag, input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int          lat, bc;
    logic [31:0] q, r;
    logic        dz;
    run_op(sop, a, b, lat, bc, q, r, dz);
    chk({tag, "_quotient"}, q, eq);
    chk({tag, "_remainder"}, r, er);
    chk({tag, "_div_by_zero"}, {31'd0, dz}, {31'd0, edz});
    chk({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, "_busy_cycles"}, 32'(bc), (b == 32'd0) ? 32'd1 : 32'd33);
  endtask

  vec_t tbl[11];

  initial begin
    logic [31:0] eq, er, q1, r1, q2, r2;
    logic        edz, dz1, dz2;
    logic [31:0] a, b;
    logic        sop;
    int          gap, seen;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    tbl[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[6]  = '{1'b0, 32'd0,          32'd1,          32'd0,          32'd0,          1'b0};
    tbl[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    tbl[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[10] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};

    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < 11; i++)
      check_op($sformatf("vec%0d", i), tbl[i].sop, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    for (int i = 0; i < 30; i++) begin
      sop = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(sop, a, b, eq, er, edz);
      check_op($sformatf("rnd%0d", i), sop, a, b, eq, er, edz);
    end

    // start held high throughout; second op captured in the first op's done cycle
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      signed_op = $urandom; dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      if (done) begin seen = 1; break; end
    end
    chk("b2b_first_done_seen", 32'(seen), 32'd1);
    q1 = quotient; r1 = remainder; dz1 = div_by_zero;
    signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5;
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin signed_op = $urandom; dividend = $urandom; divisor = $urandom; end
      if (done) begin gap = k; break; end
      signed_op = $urandom; dividend = $urandom; divisor = 32'd0;
    end
    start = 1'b0;
    q2 = quotient; r2 = remainder; dz2 = div_by_zero;
    chk("b2b_first_quotient", q1, 32'hFFFF_FFF2);
    chk("b2b_first_remainder", r1, 32'hFFFF_FFFE);
    chk("b2b_first_div_by_zero", {31'd0, dz1}, 32'd0);
    chk("b2b_done_gap", 32'(gap), 32'd34);
    chk("b2b_second_quotient", q2, 32'd15);
    chk("b2b_second_remainder", r2, 32'd2);
    chk("b2b_second_div_by_zero", {31'd0, dz2}, 32'd0);
    repeat (2) @(posedge clk);

    // asynchronous reset 10 cycles into RUN
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    check_op("after_reset", 1'b0, 32'd12, 32'd4, 32'd3, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
